// File: rtl/uart_pkg.sv
// Shared types and width helpers for the UART receive path.
package uart_pkg;

   localparam int UART_DATA_WIDTH = 8;

   // Address width for a DEPTH-entry array; never narrower than one bit.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Fill-level width: must represent 0..DEPTH inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   typedef logic [UART_DATA_WIDTH-1:0] uart_word_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int  DATA_WIDTH = UART_DATA_WIDTH,
   parameter int  DEPTH      = 16,
   localparam int AW         = ptr_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en_i,
   input  logic [AW-1:0]         wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic [AW-1:0]         rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // Capture the incoming word at the write address.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO behind the UART receiver.
// Optional build macro UART_RX_FIFO_DROP_CNT_EN adds a saturating
// 8-bit count of dropped words (drop_cnt).
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int  DATA_WIDTH  = UART_DATA_WIDTH,
   parameter int  DEPTH       = 16,
   parameter int  AFULL_LEVEL = 12,
   localparam int PW          = ptr_width(DEPTH),
   localparam int CW          = cnt_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CW-1:0]         count,
   output logic                  almost_full,
   output logic                  overflow,
   input  logic                  clr_overflow
`ifdef UART_RX_FIFO_DROP_CNT_EN
  ,output logic [7:0]            drop_cnt
`endif
);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          almost_full_q, almost_full_d;
   logic          overflow_q, overflow_d;
   logic          wr_en, rd_en, drop;

   // Handshake flags depend only on the registered fill level, so the
   // async reset clears them without waiting for an edge and in_ready
   // never sees out_ready combinationally.
   assign in_ready  = (count_q != CW'(DEPTH));
   assign out_valid = (count_q != '0);

   assign wr_en = in_valid && in_ready;
   assign rd_en = out_valid && out_ready;
   assign drop  = in_valid && !in_ready;

   // Next-state pointers, fill level, watermark and sticky overflow.
   always_comb begin
      wr_ptr_d      = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d      = rd_en ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d       = count_q;
      unique case ({wr_en, rd_en})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      almost_full_d = (count_d >= CW'(AFULL_LEVEL));
      if (drop) begin
         overflow_d = 1'b1;
      end else if (clr_overflow) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         almost_full_q <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         almost_full_q <= almost_full_d;
         overflow_q    <= overflow_d;
      end
   end

   assign count       = count_q;
   assign almost_full = almost_full_q;
   assign overflow    = overflow_q;

`ifdef UART_RX_FIFO_DROP_CNT_EN
   logic [7:0] drop_cnt_q, drop_cnt_d;

   // A drop wins over a same-cycle clear, restarting the count at one.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop) begin
         if (clr_overflow) begin
            drop_cnt_d = 8'd1;
         end else if (drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
         end
      end else if (clr_overflow) begin
         drop_cnt_d = 8'd0;
      end
   end

   // Dropped-word counter register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         drop_cnt_q <= 8'd0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt = drop_cnt_q;
`endif

   uart_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk        (clk),
      .wr_en_i    (wr_en),
      .wr_addr_i  (wr_ptr_q),
      .wr_data_i  (in_data),
      .rd_addr_i  (rd_ptr_q),
      .rd_data_o  (out_data)
   );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference.
module tb_uart_rx_fifo;
   import uart_pkg::*;

   localparam int DEPTH = 16;
   localparam int AFL   = 12;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [4:0] count;
   logic       almost_full;
   logic       overflow;
   logic       clr_overflow = 1'b0;
`ifdef UART_RX_FIFO_DROP_CNT_EN
   logic [7:0] drop_cnt;
`endif

   uart_rx_fifo #(
      .DATA_WIDTH  (8),
      .DEPTH       (DEPTH),
      .AFULL_LEVEL (AFL)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .count        (count),
      .almost_full  (almost_full),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
`ifdef UART_RX_FIFO_DROP_CNT_EN
     ,.drop_cnt     (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference: contents as a queue, plus the two sticky quantities.
   uart_word_t mdl_q [$];
   bit         mdl_ov    = 1'b0;
   int         mdl_drops = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      chk("out_valid",   32'(out_valid),   32'(mdl_q.size() != 0));
      chk("in_ready",    32'(in_ready),    32'(mdl_q.size() != DEPTH));
      chk("count",       32'(count),       32'(mdl_q.size()));
      chk("almost_full", 32'(almost_full), 32'(mdl_q.size() >= AFL));
      chk("overflow",    32'(overflow),    32'(mdl_ov));
      if (mdl_q.size() != 0) chk("out_data", 32'(out_data), 32'(mdl_q[0]));
`ifdef UART_RX_FIFO_DROP_CNT_EN
      chk("drop_cnt",    32'(drop_cnt),    32'(mdl_drops));
`endif
   endtask

   // One clock: check current outputs, drive inputs, update the reference.
   task automatic step(input bit iv, input logic [7:0] d, input bit ordy, input bit clr);
      bit full, rd, wr, drop;
      @(negedge clk);
      check_outputs();
      in_valid = iv; in_data = d; out_ready = ordy; clr_overflow = clr;
      @(posedge clk);
      full = (mdl_q.size() == DEPTH);
      rd   = ordy && (mdl_q.size() != 0);
      wr   = iv && !full;
      drop = iv && full;
      if (rd) void'(mdl_q.pop_front());
      if (wr) mdl_q.push_back(d);
      if (drop) begin
         mdl_ov    = 1'b1;
         mdl_drops = clr ? 1 : ((mdl_drops < 255) ? mdl_drops + 1 : 255);
      end else if (clr) begin
         mdl_ov    = 1'b0;
         mdl_drops = 0;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset values while reset is held.
      #3;
      chk("rst_out_valid",   32'(out_valid),   32'd0);
      chk("rst_in_ready",    32'(in_ready),    32'd1);
      chk("rst_count",       32'(count),       32'd0);
      chk("rst_almost_full", 32'(almost_full), 32'd0);
      chk("rst_overflow",    32'(overflow),    32'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      // Single word fall-through and pop.
      step(1'b1, 8'h55, 1'b0, 1'b0);
      #1;
      chk("wr55_valid", 32'(out_valid), 32'd1);
      chk("wr55_data",  32'(out_data),  32'h55);
      chk("wr55_count", 32'(count),     32'd1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      #1;
      chk("pop55_valid", 32'(out_valid), 32'd0);
      chk("pop55_count", 32'(count),     32'd0);

      // Fill to full, watching the watermark.
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, 8'(i), 1'b0, 1'b0);
         #1;
         if (i == AFL - 2) chk("af_below", 32'(almost_full), 32'd0);
         if (i == AFL - 1) chk("af_rise",  32'(almost_full), 32'd1);
      end
      chk("full_in_ready", 32'(in_ready), 32'd0);

      // Write while full with a same-cycle pop: word dropped, pop happens.
      step(1'b1, 8'hAA, 1'b1, 1'b0);
      #1;
      chk("drop_count", 32'(count),    32'd15);
      chk("drop_ov",    32'(overflow), 32'd1);
      drain();

      // Clear overflow on its own.
      step(1'b0, 8'h00, 1'b0, 1'b1);
      #1;
      chk("clr_ov", 32'(overflow), 32'd0);

      // Pointer wrap: 20-word stream with lagging reads.
      for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h80 + i), (i >= 3), 1'b0);
      drain();

      // Steady state at count 5 with simultaneous write and pop.
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 8'(8'h50 + i), 1'b1, 1'b0);
         #1;
         chk("steady_count", 32'(count), 32'd5);
      end
      drain();

      // Drop and clear in the same cycle: set wins.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
      step(1'b1, 8'hEE, 1'b0, 1'b1);
      #1;
      chk("setclr_ov", 32'(overflow), 32'd1);
`ifdef UART_RX_FIFO_DROP_CNT_EN
      chk("setclr_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
      // Hammer drops past the counter saturation point.
      for (int i = 0; i < 260; i++) step(1'b1, 8'hDD, 1'b0, 1'b0);
      drain();
      step(1'b0, 8'h00, 1'b0, 1'b1);

      // Randomized traffic: fill-biased then drain-biased phases.
      for (int i = 0; i < 500; i++)
         step(($urandom_range(0, 99) < 65), 8'($urandom), ($urandom_range(0, 99) < 40),
              ($urandom_range(0, 99) < 3));
      for (int i = 0; i < 500; i++)
         step(($urandom_range(0, 99) < 40), 8'($urandom), ($urandom_range(0, 99) < 70),
              ($urandom_range(0, 99) < 3));
      drain();

      // Asynchronous reset at count 7 mid-stream.
      for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0; clr_overflow = 1'b0;
      #2;
      rstn = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_count",     32'(count),     32'd0);
      chk("arst_in_ready",  32'(in_ready),  32'd1);
      mdl_q.delete();
      mdl_ov    = 1'b0;
      mdl_drops = 0;
      @(negedge clk);
      rstn = 1'b1;
      step(1'b1, 8'h3C, 1'b0, 1'b0);
      #1;
      chk("post_rst_data", 32'(out_data), 32'h3C);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
